// File: rtl/spart_pkg.sv
// Shared SPART definitions: frame geometry and receive FSM state encoding.
// Used by the receive stage, transmit stage and baud generator.
package spart_pkg;

  localparam int unsigned SPART_OVERSAMPLE = 16;
  localparam int unsigned SPART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; reset value is selectable
// so idle-high lines do not look like activity coming out of reset.
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: 8N1 deserialiser driven by oversampling enable pulses,
// holding the last good byte with data-available, framing and overrun flags.
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = SPART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = SPART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 brg_en,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_t state_q, state_d;

  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic start_mid;
  logic data_sample;
  logic stop_sample;

  spart_sync2 #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxd_s)
  );

  // Sampling points: middle of the start bit, then one full bit period apart.
  assign start_mid   = brg_en && (state_q == RX_START) && (tick_q == TICK_MID);
  assign data_sample = brg_en && (state_q == RX_DATA)  && (tick_q == TICK_LAST);
  assign stop_sample = brg_en && (state_q == RX_STOP)  && (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (brg_en && !rxd_s) state_d = RX_START;
      RX_START: if (start_mid) state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (data_sample && (bit_q == BIT_LAST)) state_d = RX_STOP;
      RX_STOP:  if (stop_sample) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;

    if (brg_en) begin
      if (state_q == RX_IDLE || start_mid) begin
        tick_d = '0;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end

    if (start_mid) begin
      bit_d = '0;
    end

    if (data_sample) begin
      shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
      if (bit_q != BIT_LAST) begin
        bit_d = bit_q + BIT_W'(1);
      end
    end

    if (clr_rda) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end

    // A load in the same cycle as a read overrides the clear.
    if (stop_sample) begin
      if (rxd_s) begin
        rx_data_d = shreg_q;
        rda_d     = 1'b1;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q | rda_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign rx_data = rx_data_q;
  assign rda     = rda_q;
  assign ferr    = ferr_q;
  assign ovr     = ovr_q;

endmodule
